sig_gen: RTL and testbench

Edge-event transmitter: the driving end of the edge-detection interface served by `sig_change`. Queues rise/fall/toggle/hold commands and replays them onto a single registered line `d`. Consecutive applied commands are spaced by a programmable minimum hold time, so a downstream `sig_change` sees every commanded transition as a distinct `rise`/`fall`/`toggle` pulse. Used to generate stimulus and control strobes for the edge-detection path.

---
 rtl/sig_gen.sv | 158 +++++++++++++++
 tb/tb_sig_gen.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/sig_gen.sv
// sig_gen: edge-event transmitter.
//
// Queues rise/fall/toggle/hold commands in a small FIFO and replays them onto
// a single registered line `d`. Consecutive applications are spaced HOLD
// cycles apart, so a downstream edge detector sees every commanded transition
// as its own pulse.
//
// Parameters:
//   HOLD  - cycles between consecutive command applications (>= 1)
//   DEPTH - command FIFO depth (power of 2, >= 2)
//   INIT  - reset level of `d`
//
// Ports:
//   clk        in   clock, rising-edge
//   reset      in   asynchronous, active-low; clears all state immediately
//   cmd_valid  in   command present on `cmd`
//   cmd        in   2'b00 hold, 2'b01 rise, 2'b10 fall, 2'b11 toggle
//   cmd_ready  out  FIFO not full (push on cmd_valid & cmd_ready)
//   d          out  generated line, registered
//   busy       out  FIFO non-empty or hold window in progress
//   redundant  out  one-cycle pulse: rise applied with d=1 / fall with d=0
module sig_gen #(
  parameter int HOLD  = 4,
  parameter int DEPTH = 4,
  parameter bit INIT  = 1'b0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       cmd_valid,
  input  logic [1:0] cmd,
  output logic       cmd_ready,
  output logic       d,
  output logic       busy,
  output logic       redundant
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  // The counter only ever holds values up to HOLD-1.
  localparam int HW = (HOLD > 1) ? $clog2(HOLD) : 1;

  localparam logic [CW-1:0] FULL_CNT  = CW'(DEPTH);
  localparam logic [HW-1:0] HOLD_LOAD = HW'(HOLD - 1);

  localparam logic [1:0] CMD_RISE   = 2'b01;
  localparam logic [1:0] CMD_FALL   = 2'b10;
  localparam logic [1:0] CMD_TOGGLE = 2'b11;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_HOLD = 1'b1
  } state_t;

  // Command storage. Not reset: after reset the pointers and count mark
  // every entry as empty, so stale contents are never read.
  logic [1:0]    fifo_mem [DEPTH];

  logic [AW-1:0] wr_ptr_reg;
  logic [AW-1:0] rd_ptr_reg;
  logic [CW-1:0] count_reg;
  state_t        state_reg;
  logic [HW-1:0] hold_cnt_reg;
  logic          d_reg;
  logic          redundant_reg;

  logic          push;
  logic          pop;
  logic [1:0]    head;
  logic          d_next;
  logic          redundant_next;

  // Ready comes from the registered count only: a pop in the same cycle does
  // not open a slot for a push while full.
  assign cmd_ready = (count_reg != FULL_CNT);
  // Gating with reset keeps the storage untouched while reset is asserted.
  assign push      = cmd_valid & cmd_ready & reset;
  assign pop       = (state_reg == ST_IDLE) && (count_reg != '0);
  assign head      = fifo_mem[rd_ptr_reg];

  assign d         = d_reg;
  assign redundant = redundant_reg;
  assign busy      = (count_reg != '0) || (state_reg == ST_HOLD);

  // Effect of applying the head command this edge.
  always_comb begin
    d_next         = d_reg;
    redundant_next = 1'b0;
    if (pop) begin
      case (head)
        CMD_RISE: begin
          d_next         = 1'b1;
          redundant_next = d_reg;
        end
        CMD_FALL: begin
          d_next         = 1'b0;
          redundant_next = ~d_reg;
        end
        CMD_TOGGLE: d_next = ~d_reg;
        default:    d_next = d_reg;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr_reg] <= cmd;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_reg    <= '0;
      rd_ptr_reg    <= '0;
      count_reg     <= '0;
      state_reg     <= ST_IDLE;
      hold_cnt_reg  <= '0;
      d_reg         <= INIT;
      redundant_reg <= 1'b0;
    end else begin
      d_reg         <= d_next;
      redundant_reg <= redundant_next;

      if (push) begin
        wr_ptr_reg <= wr_ptr_reg + AW'(1);
      end
      if (pop) begin
        rd_ptr_reg <= rd_ptr_reg + AW'(1);
      end

      case ({push, pop})
        2'b10:   count_reg <= count_reg + CW'(1);
        2'b01:   count_reg <= count_reg - CW'(1);
        default: count_reg <= count_reg;
      endcase

      // With HOLD = 1 the FSM never leaves IDLE and pops every cycle.
      case (state_reg)
        ST_IDLE: begin
          if (pop && (HOLD > 1)) begin
            state_reg    <= ST_HOLD;
            hold_cnt_reg <= HOLD_LOAD;
          end
        end
        ST_HOLD: begin
          hold_cnt_reg <= hold_cnt_reg - HW'(1);
          if (hold_cnt_reg == HW'(1)) begin
            state_reg <= ST_IDLE;
          end
        end
        default: begin
          state_reg    <= ST_IDLE;
          hold_cnt_reg <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sig_gen.sv
// tb_sig_gen: self-checking bench for sig_gen.
//
// Reference model: a queue of pending commands plus the edge index of the
// last application. A command may be applied at any edge that is at least
// HOLD edges after the previous application; the line is busy while the
// queue holds entries or while fewer than HOLD-1 edges have passed since
// the last application.
module tb_sig_gen;

  localparam int HOLD  = 4;
  localparam int DEPTH = 4;
  localparam bit INIT  = 1'b0;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       cmd_valid = 1'b0;
  logic [1:0] cmd = 2'b00;
  logic       cmd_ready;
  logic       d;
  logic       busy;
  logic       redundant;

  sig_gen #(
    .HOLD (HOLD),
    .DEPTH(DEPTH),
    .INIT (INIT)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .cmd_valid(cmd_valid),
    .cmd      (cmd),
    .cmd_ready(cmd_ready),
    .d        (d),
    .busy     (busy),
    .redundant(redundant)
  );

  always #5 clk = ~clk;

  int num_checks = 0;
  int num_fails  = 0;

  // Behavioural model state.
  logic [1:0] m_q[$];
  bit         m_d;
  bit         m_red;
  int         edge_no;
  int         last_apply;
  int         pushes;
  int         applies;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    num_checks++;
    if (obs !== exp) begin
      num_fails++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic bit m_ready();
    return m_q.size() != DEPTH;
  endfunction

  function automatic bit m_busy();
    return (m_q.size() != 0) || (edge_no < last_apply + HOLD - 1);
  endfunction

  task automatic model_reset();
    m_q.delete();
    m_d        = INIT;
    m_red      = 1'b0;
    last_apply = -1000;
  endtask

  // One rising edge with reset released.
  task automatic model_edge(input bit v, input logic [1:0] c);
    bit         rdy;
    logic [1:0] h;
    rdy   = m_ready();
    edge_no++;
    m_red = 1'b0;
    if (m_q.size() > 0 && edge_no >= last_apply + HOLD) begin
      h = m_q.pop_front();
      case (h)
        2'b01: begin m_red = m_d;  m_d = 1'b1; end
        2'b10: begin m_red = ~m_d; m_d = 1'b0; end
        2'b11: m_d = ~m_d;
        default: ;
      endcase
      last_apply = edge_no;
      applies++;
      $display("edge %0d: apply cmd=%b -> d=%0d redundant=%0d", edge_no, h, m_d, m_red);
    end
    if (v && rdy) begin
      m_q.push_back(c);
      pushes++;
      $display("edge %0d: push cmd=%b (queued=%0d)", edge_no, c, m_q.size());
    end
  endtask

  task automatic check_all(input string tag);
    check_eq({tag, ".d"},         d,         m_d);
    check_eq({tag, ".busy"},      busy,      m_busy());
    check_eq({tag, ".cmd_ready"}, cmd_ready, m_ready());
    check_eq({tag, ".redundant"}, redundant, m_red);
  endtask

  // Called at a falling edge: check outputs, drive inputs, advance one edge.
  task automatic tick(input bit v, input logic [1:0] c, input string tag);
    check_all(tag);
    cmd_valid = v;
    cmd       = c;
    @(posedge clk);
    if (reset) model_edge(v, c);
    @(negedge clk);
  endtask

  task automatic idle(input int n, input string tag);
    for (int i = 0; i < n; i++) tick(1'b0, 2'b00, tag);
  endtask

  initial begin
    edge_no = 0;
    pushes  = 0;
    applies = 0;
    model_reset();

    // 1. Reset held with a valid command present.
    reset     = 1'b0;
    cmd_valid = 1'b1;
    cmd       = 2'b01;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_all("rst");
    end
    check_eq("rst.d_init", d, INIT);
    reset = 1'b1;
    idle(4, "post_rst");
    check_eq("post_rst.d_const", d, INIT);

    // 2. Single rise: applied one edge after the push.
    tick(1'b1, 2'b01, "single");
    check_eq("single.busy_queued", busy, 1);
    tick(1'b0, 2'b00, "single");
    check_eq("single.latency_d", d, 1);
    idle(6, "single");
    check_eq("single.busy_done", busy, 0);

    // Return the line low, then 3. back-to-back rise, fall, toggle.
    tick(1'b1, 2'b10, "pre_b2b");
    idle(5, "pre_b2b");
    tick(1'b1, 2'b01, "b2b");
    tick(1'b1, 2'b10, "b2b");
    tick(1'b1, 2'b11, "b2b");
    idle(12, "b2b");
    check_eq("b2b.final_d", d, 1);

    // 4. Continuous pressure: fills the FIFO and wraps the pointers.
    for (int i = 0; i < 20; i++) tick(1'b1, (i % 2 == 0) ? 2'b11 : 2'b00, "full");
    idle(25, "drain");
    check_eq("drain.empty_busy", busy, 0);
    check_eq("drain.all_applied", applies, pushes);

    // 5. Redundant rise followed by a fall.
    tick(1'b1, 2'b01, "red_setup");
    idle(5, "red_setup");
    check_eq("red_setup.d", d, 1);
    tick(1'b1, 2'b01, "red");
    tick(1'b1, 2'b10, "red");
    check_eq("red.pulse", redundant, 1);
    idle(12, "red");
    check_eq("red.fall_d", d, 0);

    // 6. Reset during a hold window with two entries queued.
    tick(1'b1, 2'b11, "mid");
    tick(1'b1, 2'b10, "mid");
    tick(1'b1, 2'b01, "mid");
    tick(1'b0, 2'b00, "mid");
    check_eq("mid.pre_d", d, 1);
    #2 reset = 1'b0;
    model_reset();
    #1;
    check_eq("mid.rst_d", d, INIT);
    check_eq("mid.rst_busy", busy, 0);
    check_eq("mid.rst_ready", cmd_ready, 1);
    @(negedge clk);
    check_all("mid_rst");
    reset = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick(1'b0, 2'b00, "quiet");
      check_eq("quiet.d", d, INIT);
    end

    // Randomized traffic against the model.
    for (int i = 0; i < 400; i++) begin
      tick(($urandom_range(0, 99) < 40), 2'($urandom_range(0, 3)), "rand");
    end
    idle(30, "rand_drain");
    check_eq("rand_drain.busy", busy, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", num_checks, num_fails);
    $finish;
  end

endmodule
